comparator_response_checker: RTL and testbench

//   Synthesizable self-checking scoreboard for the 2-bit comparator (A_eq_B/A_gt_B/A_lt_B).

---
 rtl/comparator_response_checker.sv | 149 ++++++++++++++
 tb/tb_comparator_response_checker.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/comparator_response_checker.sv
// Response-side scoreboard for a WIDTH-bit magnitude comparator: checks each sampled
// {eq,gt,lt} flag set against a golden compare, counts errors and tracks {a,b} coverage.
module comparator_response_checker #(
   parameter int WIDTH = 2,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             stop,
   input  logic             vec_valid,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             a_eq_b,
   input  logic             a_gt_b,
   input  logic             a_lt_b,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [CNT_W-1:0] err_cnt,
   output logic [CNT_W-1:0] vec_cnt,
   output logic [WIDTH-1:0] fail_a,
   output logic [WIDTH-1:0] fail_b,
   output logic [2:0]       fail_flags
);

   localparam int NVEC = 2 ** (2 * WIDTH);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
   logic [CNT_W-1:0] vec_cnt_q, vec_cnt_d;
   logic [WIDTH-1:0] fail_a_q, fail_a_d;
   logic [WIDTH-1:0] fail_b_q, fail_b_d;
   logic [2:0]       fail_flags_q, fail_flags_d;
   logic [NVEC-1:0]  cov_q, cov_d;
   logic             first_fail_q, first_fail_d;
   logic             pass_q, pass_d;

   logic [2:0]       dut_flags;
   logic [2:0]       exp_flags;
   logic             mismatch;
   logic             sample;
   logic [NVEC-1:0]  vec_onehot;
   logic             cov_full_next;

   assign dut_flags = {a_eq_b, a_gt_b, a_lt_b};
   assign exp_flags = {a == b, a > b, a < b};
   // Exact compare, so any non-one-hot flag pattern is a mismatch by construction.
   assign mismatch  = (dut_flags != exp_flags);
   assign sample    = (state_q == S_RUN) && vec_valid && !start;

   always_comb begin
      vec_onehot         = '0;
      vec_onehot[{a, b}] = 1'b1;
   end

   assign cov_full_next = &(cov_q | (vec_onehot & {NVEC{sample}}));

   // NOTE: every variable gets its hold value first so no path through the case infers a latch.
   always_comb begin
      state_d      = state_q;
      err_cnt_d    = err_cnt_q;
      vec_cnt_d    = vec_cnt_q;
      fail_a_d     = fail_a_q;
      fail_b_d     = fail_b_q;
      fail_flags_d = fail_flags_q;
      cov_d        = cov_q;
      first_fail_d = first_fail_q;
      pass_d       = pass_q;

      if (start) begin
         state_d      = S_RUN;
         err_cnt_d    = '0;
         vec_cnt_d    = '0;
         fail_a_d     = '0;
         fail_b_d     = '0;
         fail_flags_d = '0;
         cov_d        = '0;
         first_fail_d = 1'b0;
         pass_d       = 1'b0;
      end else begin
         case (state_q)
            S_RUN: begin
               if (sample) begin
                  if (vec_cnt_q != '1) vec_cnt_d = vec_cnt_q + CNT_W'(1);
                  cov_d = cov_q | vec_onehot;
                  if (mismatch) begin
                     if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_W'(1);
                     if (!first_fail_q) begin
                        first_fail_d = 1'b1;
                        fail_a_d     = a;
                        fail_b_d     = b;
                        fail_flags_d = dut_flags;
                     end
                  end
               end
               // pass uses the post-update error count so the completing vector is judged too.
               if (cov_full_next || stop) begin
                  state_d = S_DONE;
                  pass_d  = (err_cnt_d == '0) && cov_full_next;
               end
            end
            default: ;
         endcase
      end
   end

   // NOTE: the coverage bitmap is a plain flop vector, not a RAM, so it is safe to reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         err_cnt_q    <= '0;
         vec_cnt_q    <= '0;
         fail_a_q     <= '0;
         fail_b_q     <= '0;
         fail_flags_q <= '0;
         cov_q        <= '0;
         first_fail_q <= 1'b0;
         pass_q       <= 1'b0;
      end else begin
         // NOTE: non-blocking so every register samples the pre-edge values of the others.
         state_q      <= state_d;
         err_cnt_q    <= err_cnt_d;
         vec_cnt_q    <= vec_cnt_d;
         fail_a_q     <= fail_a_d;
         fail_b_q     <= fail_b_d;
         fail_flags_q <= fail_flags_d;
         cov_q        <= cov_d;
         first_fail_q <= first_fail_d;
         pass_q       <= pass_d;
      end
   end

   assign busy       = (state_q == S_RUN);
   assign done       = (state_q == S_DONE);
   assign pass       = pass_q;
   assign err_cnt    = err_cnt_q;
   assign vec_cnt    = vec_cnt_q;
   assign fail_a     = fail_a_q;
   assign fail_b     = fail_b_q;
   assign fail_flags = fail_flags_q;

endmodule

// File: tb/tb_comparator_response_checker.sv
// Directed bench: a spec-level scoreboard model checked every cycle against two instances
// (8-bit and 3-bit counters), plus hand-computed literal expectations per scenario.
module tb_comparator_response_checker;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0, stop = 1'b0, vec_valid = 1'b0;
   logic [1:0] a = '0, b = '0;
   logic       a_eq_b = 1'b0, a_gt_b = 1'b0, a_lt_b = 1'b0;

   logic       busy8, done8, pass8;
   logic [7:0] err8, vec8;
   logic [1:0] fa8, fb8;
   logic [2:0] ff8;
   logic       busy3, done3, pass3;
   logic [2:0] err3, vec3;
   logic [1:0] fa3, fb3;
   logic [2:0] ff3;

   comparator_response_checker #(.WIDTH(2), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .vec_valid(vec_valid),
      .a(a), .b(b), .a_eq_b(a_eq_b), .a_gt_b(a_gt_b), .a_lt_b(a_lt_b),
      .busy(busy8), .done(done8), .pass(pass8), .err_cnt(err8), .vec_cnt(vec8),
      .fail_a(fa8), .fail_b(fb8), .fail_flags(ff8)
   );

   comparator_response_checker #(.WIDTH(2), .CNT_W(3)) dut3 (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .vec_valid(vec_valid),
      .a(a), .b(b), .a_eq_b(a_eq_b), .a_gt_b(a_gt_b), .a_lt_b(a_lt_b),
      .busy(busy3), .done(done3), .pass(pass3), .err_cnt(err3), .vec_cnt(vec3),
      .fail_a(fa3), .fail_b(fb3), .fail_flags(ff3)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model: unsaturated counts, a seen-pair table and a first-failure record.
   bit         m_busy, m_done, m_pass, m_first;
   int         m_err, m_vec;
   bit         m_seen[16];
   logic [1:0] m_fa, m_fb;
   logic [2:0] m_ff;

   function automatic int sat(int v, int w);
      int mx;
      mx = (1 << w) - 1;
      return (v > mx) ? mx : v;
   endfunction

   function automatic logic [2:0] gold(int x, int y);
      return {x == y, x > y, x < y};
   endfunction

   task automatic model_clear();
      m_pass = 0; m_first = 0; m_err = 0; m_vec = 0;
      m_fa = '0; m_fb = '0; m_ff = '0;
      for (int i = 0; i < 16; i++) m_seen[i] = 0;
   endtask

   task automatic model_reset();
      model_clear();
      m_busy = 0; m_done = 0;
   endtask

   task automatic model_step(input bit s, input bit st, input bit v,
                             input logic [1:0] ta, input logic [1:0] tb, input logic [2:0] fl);
      int nseen;
      if (s) begin
         model_clear();
         m_busy = 1; m_done = 0;
      end else if (m_busy) begin
         if (v) begin
            m_vec++;
            m_seen[int'(ta) * 4 + int'(tb)] = 1;
            if (fl != gold(int'(ta), int'(tb))) begin
               m_err++;
               if (!m_first) begin
                  m_first = 1; m_fa = ta; m_fb = tb; m_ff = fl;
               end
            end
         end
         nseen = 0;
         for (int i = 0; i < 16; i++) nseen += int'(m_seen[i]);
         if (nseen == 16 || st) begin
            m_busy = 0; m_done = 1;
            m_pass = (m_err == 0) && (nseen == 16);
         end
      end
   endtask

   task automatic step(input bit s, input bit st, input bit v,
                       input logic [1:0] ta, input logic [1:0] tb, input logic [2:0] fl);
      @(negedge clk);
      start = s; stop = st; vec_valid = v; a = ta; b = tb;
      {a_eq_b, a_gt_b, a_lt_b} = fl;
      @(posedge clk);
      model_step(s, st, v, ta, tb, fl);
   endtask

   task automatic idle();
      step(0, 0, 0, 2'd0, 2'd0, 3'b000);
   endtask

   // Per-cycle comparison of both instances against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         check("busy8", busy8, m_busy);
         check("done8", done8, m_done);
         check("pass8", pass8, m_pass);
         check("err8",  err8,  sat(m_err, 8));
         check("vec8",  vec8,  sat(m_vec, 8));
         check("fa8",   fa8,   m_fa);
         check("fb8",   fb8,   m_fb);
         check("ff8",   ff8,   m_ff);
         check("busy3", busy3, m_busy);
         check("done3", done3, m_done);
         check("pass3", pass3, m_pass);
         check("err3",  err3,  sat(m_err, 3));
         check("vec3",  vec3,  sat(m_vec, 3));
         check("fa3",   fa3,   m_fa);
         check("fb3",   fb3,   m_fb);
         check("ff3",   ff3,   m_ff);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("reset_busy", busy8, 0);
      check("reset_done", done8, 0);
      check("reset_err",  err8,  0);
      check("reset_vec",  vec8,  0);
      @(negedge clk);
      rst = 1'b0;
      chk_en = 1'b1;

      // 1: clean sweep; vector presented with start is ignored.
      step(1, 0, 1, 2'd3, 2'd3, 3'b000);
      for (int i = 0; i < 16; i++) begin
         step(0, 0, 1, 2'(i / 4), 2'(i % 4), gold(i / 4, i % 4));
         if (i == 14) begin #1; check("t1_done_early", done8, 0); end
      end
      #1;
      check("t1_done", done8, 1);
      check("t1_busy", busy8, 0);
      check("t1_pass", pass8, 1);
      check("t1_err",  err8,  0);
      check("t1_vec",  vec8,  16);
      idle();

      // 2: single bad response at A=2,B=1.
      step(1, 0, 0, 2'd0, 2'd0, 3'b000);
      for (int i = 0; i < 16; i++)
         step(0, 0, 1, 2'(i / 4), 2'(i % 4), (i == 9) ? 3'b001 : gold(i / 4, i % 4));
      #1;
      check("t2_done", done8, 1);
      check("t2_err",  err8,  1);
      check("t2_fa",   fa8,   2);
      check("t2_fb",   fb8,   1);
      check("t2_ff",   ff8,   3'b001);
      check("t2_pass", pass8, 0);

      // 3: restart inside RUN, then two bad responses; first one is captured.
      step(1, 0, 0, 2'd0, 2'd0, 3'b000);
      for (int i = 0; i < 3; i++) step(0, 0, 1, 2'd3, 2'd0, 3'b100);
      step(1, 0, 0, 2'd0, 2'd0, 3'b000);
      #1;
      check("t3_restart_busy", busy8, 1);
      check("t3_restart_vec",  vec8,  0);
      check("t3_restart_err",  err8,  0);
      for (int i = 0; i < 16; i++)
         step(0, 0, 1, 2'(i / 4), 2'(i % 4),
              (i == 5) ? 3'b000 : (i == 12) ? 3'b011 : gold(i / 4, i % 4));
      #1;
      check("t3_err", err8, 2);
      check("t3_fa",  fa8,  1);
      check("t3_fb",  fb8,  1);
      check("t3_ff",  ff8,  3'b000);

      // 4: 20 vectors over 15 pairs, stop together with the last vector.
      step(1, 0, 0, 2'd0, 2'd0, 3'b000);
      for (int i = 0; i < 15; i++) step(0, 0, 1, 2'(i / 4), 2'(i % 4), gold(i / 4, i % 4));
      for (int i = 0; i < 5; i++)
         step(0, (i == 4), 1, 2'(i / 4), 2'(i % 4), gold(i / 4, i % 4));
      #1;
      check("t4_done", done8, 1);
      check("t4_vec",  vec8,  20);
      check("t4_vec3", vec3,  7);
      check("t4_err",  err8,  0);
      check("t4_pass", pass8, 0);

      // 5: error counter saturation, then start from DONE.
      step(1, 0, 0, 2'd0, 2'd0, 3'b000);
      for (int i = 0; i < 10; i++) step(0, 0, 1, 2'd0, 2'd0, 3'b000);
      step(0, 1, 0, 2'd0, 2'd0, 3'b000);
      #1;
      check("t5_err3", err3,  7);
      check("t5_err8", err8,  10);
      check("t5_done", done3, 1);
      step(1, 0, 0, 2'd0, 2'd0, 3'b000);
      #1;
      check("t5_busy", busy3, 1);
      check("t5_err0", err3,  0);
      check("t5_vec0", vec3,  0);

      // 6: asynchronous reset between edges, then vectors without start.
      for (int i = 0; i < 5; i++) step(0, 0, 1, 2'(i), 2'd1, gold(i, 1));
      #1;
      check("t6_vec_pre", vec8, 5);
      #1;
      rst = 1'b1;
      model_reset();
      #1;
      check("t6_rst_busy", busy8, 0);
      check("t6_rst_vec",  vec8,  0);
      check("t6_rst_err",  err8,  0);
      check("t6_rst_done", done8, 0);
      #1;
      rst = 1'b0;
      for (int i = 0; i < 3; i++) step(0, 0, 1, 2'd2, 2'd2, 3'b000);
      #1;
      check("t6_ign_vec",  vec8,  0);
      check("t6_ign_err",  err8,  0);
      check("t6_ign_busy", busy8, 0);
      idle();
      idle();

      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
